p_fxp_mac: RTL

- Pipelined fixed-point multiply-accumulate unit for perceptron neuron evaluation.
- Accepts a stream of `len` (in1, in2) operand pairs over a valid/ready handshake and sums their full-precision products in a widened accumulator.
- Reduces the final sum to the O_CONF format with saturation and udf/ovf/rounded status, then holds it on a valid/ready output port.
- Successor to the combinational fixed-point multiplier: adds accumulation, a run-length count, pipelining, backpressure and saturation.

---
 rtl/p_fxp_mac.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/p_fxp_mac.sv
// Pipelined fixed-point multiply-accumulate for perceptron neurons: streams len operand
// pairs, accumulates full-precision products, then saturates/truncates into the output format.
package p_fxp_mac_pkg;
    typedef struct packed {
        logic sign;
        int   prec;
        int   frac;
    } dconf_t;
endpackage

`ifndef DEF_DCONF_FXP
`define DEF_DCONF_FXP p_fxp_mac_pkg::dconf_t'{sign: 1'b1, prec: 16, frac: 8}
`endif

module p_fxp_mac
    import p_fxp_mac_pkg::*;
#(
    parameter dconf_t I1_CONF = `DEF_DCONF_FXP,
    parameter dconf_t I2_CONF = `DEF_DCONF_FXP,
    parameter dconf_t O_CONF  = `DEF_DCONF_FXP,
    parameter int     LEN_W   = 8,
    parameter int     ACC_EXT = LEN_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [I1_CONF.prec-1:0] in1,
    input  logic [I2_CONF.prec-1:0] in2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [O_CONF.prec-1:0]  out,
    output logic                    udf,
    output logic                    ovf,
    output logic                    rounded,
    output logic                    busy
);

    localparam bit E_SIGN = I1_CONF.sign | I2_CONF.sign;
    localparam int E_PREC = I1_CONF.prec + I2_CONF.prec;
    localparam int E_FRAC = I1_CONF.frac + I2_CONF.frac;
    localparam int A_PREC = E_PREC + ACC_EXT;
    localparam int SH     = E_FRAC - O_CONF.frac;
    localparam int RSH    = (SH > 0) ? SH : 0;
    localparam int LSH    = (SH < 0) ? -SH : 0;
    localparam int R_W    = ((A_PREC + LSH > O_CONF.prec) ? (A_PREC + LSH) : O_CONF.prec) + 2;

    localparam logic [A_PREC-1:0]     RND_MASK = (A_PREC'(1) << RSH) - A_PREC'(1);
    localparam logic signed [R_W-1:0] O_MAX = O_CONF.sign ?
        ((R_W'(1) << (O_CONF.prec - 1)) - R_W'(1)) : ((R_W'(1) << O_CONF.prec) - R_W'(1));
    localparam logic signed [R_W-1:0] O_MIN = O_CONF.sign ?
        (-(R_W'(1) << (O_CONF.prec - 1))) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [LEN_W-1:0]       len_reg, cnt_reg, cnt_inc;
    logic [E_PREC-1:0]      p_reg;
    logic                   pv_reg;
    logic [A_PREC-1:0]      acc_reg;
    logic                   acc_pos_reg, acc_neg_reg;
    logic [O_CONF.prec-1:0] out_reg;
    logic                   udf_reg, ovf_reg, rnd_reg;

    logic                   accept;
    logic [E_PREC-1:0]      op1_ext, op2_ext, prod;
    logic [A_PREC-1:0]      p_ext, sum_val;
    logic                   add_pos, add_neg;
    logic signed [R_W-1:0]  acc_wide, red_shift;
    logic [O_CONF.prec-1:0] red_out;
    logic                   red_udf, red_ovf, red_rnd;

    // Operands are widened to the product width before multiplying; because the true
    // product always fits in E_PREC bits, the low half of an unsigned multiply is exact.
    generate
        if (I1_CONF.sign) begin : g_op1_sext
            assign op1_ext = {{(E_PREC - I1_CONF.prec){in1[I1_CONF.prec-1]}}, in1};
        end else begin : g_op1_zext
            assign op1_ext = {{(E_PREC - I1_CONF.prec){1'b0}}, in1};
        end
        if (I2_CONF.sign) begin : g_op2_sext
            assign op2_ext = {{(E_PREC - I2_CONF.prec){in2[I2_CONF.prec-1]}}, in2};
        end else begin : g_op2_zext
            assign op2_ext = {{(E_PREC - I2_CONF.prec){1'b0}}, in2};
        end
    endgenerate

    assign prod    = op1_ext * op2_ext;
    assign cnt_inc = cnt_reg + LEN_W'(1);

    generate
        if (E_SIGN) begin : g_acc_signed
            logic [A_PREC-1:0] sum_s;
            assign p_ext   = {{ACC_EXT{p_reg[E_PREC-1]}}, p_reg};
            assign sum_s   = acc_reg + p_ext;
            assign sum_val = sum_s;
            assign add_pos = ~acc_reg[A_PREC-1] & ~p_ext[A_PREC-1] &  sum_s[A_PREC-1];
            assign add_neg =  acc_reg[A_PREC-1] &  p_ext[A_PREC-1] & ~sum_s[A_PREC-1];
            assign acc_wide = {{(R_W - A_PREC){acc_reg[A_PREC-1]}}, acc_reg};
        end else begin : g_acc_unsigned
            logic [A_PREC:0] sum_u;
            assign p_ext   = {{ACC_EXT{1'b0}}, p_reg};
            assign sum_u   = {1'b0, acc_reg} + {1'b0, p_ext};
            assign sum_val = sum_u[A_PREC-1:0];
            assign add_pos = sum_u[A_PREC];
            assign add_neg = 1'b0;
            assign acc_wide = {{(R_W - A_PREC){1'b0}}, acc_reg};
        end
    endgenerate

    // Arithmetic right shift truncates toward -inf; a negative shift becomes a left shift.
    assign red_shift = (acc_wide >>> RSH) <<< LSH;
    assign red_rnd   = |(acc_reg & RND_MASK);

    always_comb begin
        red_out = red_shift[O_CONF.prec-1:0];
        red_ovf = 1'b0;
        red_udf = 1'b0;
        if (acc_pos_reg || (red_shift > O_MAX)) begin
            red_out = O_MAX[O_CONF.prec-1:0];
            red_ovf = 1'b1;
        end else if (acc_neg_reg || (red_shift < O_MIN)) begin
            red_out = O_MIN[O_CONF.prec-1:0];
            red_udf = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && (cnt_inc == len_reg)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pv_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_reg     <= '0;
            cnt_reg     <= '0;
            p_reg       <= '0;
            pv_reg      <= 1'b0;
            acc_reg     <= '0;
            acc_pos_reg <= 1'b0;
            acc_neg_reg <= 1'b0;
            out_reg     <= '0;
            udf_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
            rnd_reg     <= 1'b0;
        end else begin
            pv_reg <= accept;
            if (accept) begin
                p_reg   <= prod;
                cnt_reg <= cnt_inc;
            end
            // Accumulator overflow flags are sticky so a wrapped sum still saturates.
            if (pv_reg) begin
                acc_reg     <= sum_val;
                acc_pos_reg <= acc_pos_reg | add_pos;
                acc_neg_reg <= acc_neg_reg | add_neg;
            end
            if (state_reg == ST_IDLE && start) begin
                len_reg     <= len;
                cnt_reg     <= '0;
                acc_reg     <= '0;
                acc_pos_reg <= 1'b0;
                acc_neg_reg <= 1'b0;
                if (len == '0) begin
                    out_reg <= '0;
                    udf_reg <= 1'b0;
                    ovf_reg <= 1'b0;
                    rnd_reg <= 1'b0;
                end
            end
            if (state_reg == ST_DRAIN && !pv_reg) begin
                out_reg <= red_out;
                udf_reg <= red_udf;
                ovf_reg <= red_ovf;
                rnd_reg <= red_rnd;
            end
        end
    end

    assign out     = out_reg;
    assign udf     = udf_reg;
    assign ovf     = ovf_reg;
    assign rounded = rnd_reg;

endmodule
